// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  // fetch stage side: issues requests, receives data
  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata
  );

  // memory side: serves requests
  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding imem requests, 2-entry prefetch
// FIFO with same-cycle bypass, branch/jump redirect with stale-ack discard.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        doBranch_id,
  input  logic [31:0] imm_for_branch,
  if_stage_if.master  imem,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid
);

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] word;
  } fq_ent_t;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  fq_ent_t [1:0] fq_q, fq_d;
  logic          head_q, head_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          outst_q, outst_d;
  logic          discard_q, discard_d;
  logic          run_q, run_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   inst_q, inst_d;
  logic          vld_q, vld_d;

  logic          req, ack_live, ack_use, redirect, push, pop, wr_idx;
  logic [31:0]   addr, imm_sh, target, fetch_pc_inc;

  // An outstanding request keeps its latched address even if fetch_pc is
  // redirected underneath it; only a fresh request looks at fetch_pc.
  // run_q holds requests off until the first edge after reset release.
  assign req          = run_q & (outst_q | (cnt_q != 2'd2));
  assign addr         = outst_q ? req_addr_q : fetch_pc_q;
  assign imem.imem_req  = req;
  assign imem.imem_addr = addr;

  // acks without a live request are ignored
  assign ack_live     = imem.imem_ack & req;
  assign ack_use      = ack_live & ~discard_q;
  assign redirect     = doBranch_id & ~stall & vld_q;
  assign imm_sh       = imm_for_branch << 2;
  assign target       = ((inst_q[31:26] == OP_J) || (inst_q[31:26] == OP_JAL)) ?
                        imm_sh : pc_q + imm_sh;
  assign fetch_pc_inc = fetch_pc_q + 32'd4;
  assign wr_idx       = head_q ^ cnt_q[0];

  assign pc         = pc_q;
  assign inst       = inst_q;
  assign inst_valid = vld_q;

  // next-state: request tracking, FIFO push/pop, output register, redirect
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    fq_d       = fq_q;
    head_d     = head_q;
    cnt_d      = cnt_q;
    discard_d  = discard_q;
    run_d      = 1'b1;
    pc_d       = pc_q;
    inst_d     = inst_q;
    vld_d      = vld_q;
    push       = 1'b0;
    pop        = 1'b0;
    outst_d    = req & ~imem.imem_ack;
    req_addr_d = addr;

    if (ack_live && discard_q) discard_d = 1'b0;

    if (redirect) begin
      // flush everything; data acked this cycle is simply not captured
      fetch_pc_d = target;
      cnt_d      = 2'd0;
      head_d     = 1'b0;
      inst_d     = NOP_INST;
      vld_d      = 1'b0;
      if (req && !imem.imem_ack) discard_d = 1'b1;
    end else begin
      if (ack_use) fetch_pc_d = fetch_pc_inc;
      if (stall) begin
        push = ack_use;
      end else if (cnt_q != 2'd0) begin
        pc_d   = fq_q[head_q].pc4;
        inst_d = fq_q[head_q].word;
        vld_d  = 1'b1;
        pop    = 1'b1;
        push   = ack_use;
      end else if (ack_use) begin
        // empty FIFO: hand the arriving word straight to decode
        pc_d   = fetch_pc_inc;
        inst_d = imem.imem_rdata;
        vld_d  = 1'b1;
      end else begin
        inst_d = NOP_INST;
        vld_d  = 1'b0;
      end
      if (push) fq_d[wr_idx] = '{pc4: fetch_pc_inc, word: imem.imem_rdata};
      if (pop)  head_d = ~head_q;
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      fq_q       <= '0;
      head_q     <= 1'b0;
      cnt_q      <= 2'd0;
      outst_q    <= 1'b0;
      discard_q  <= 1'b0;
      run_q      <= 1'b0;
      req_addr_q <= '0;
      pc_q       <= '0;
      inst_q     <= NOP_INST;
      vld_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      fq_q       <= fq_d;
      head_q     <= head_d;
      cnt_q      <= cnt_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      run_q      <= run_d;
      req_addr_q <= req_addr_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      vld_q      <= vld_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: cycle table over a zero-wait memory (stream, stall,
// relative branch, stalled branch, address wrap) plus hand sequences for a
// jump over a slow memory and reset in the middle of a request.
module tb_if_stage;
  localparam logic [31:0] NOP    = 32'hFFFF_0000;
  localparam logic [31:0] J_WORD = {6'b000010, 26'h40};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [31:0] imm = '0;
  logic [31:0] pc, inst;
  logic        inst_valid;

  int          n_cmp = 0;
  int          n_err = 0;
  int          lat = 0;
  int          wait_cnt = 0;
  logic [31:0] j_addr = 32'hFFFF_FFF0;

  if_stage_if bus();

  if_stage #(.RESET_PC(32'h0), .NOP_INST(NOP)) dut (
    .clk(clk), .reset(rst_n), .stall(stall), .doBranch_id(br),
    .imm_for_branch(imm), .imem(bus), .pc(pc), .inst(inst),
    .inst_valid(inst_valid)
  );

  always #5 clk = ~clk;

  // memory model: word = 0xA000_0000 | addr, one J at j_addr, ack after lat waits
  assign bus.imem_ack = bus.imem_req && (wait_cnt >= lat);
  always_comb begin
    bus.imem_rdata = 32'hA000_0000 | bus.imem_addr;
    if (bus.imem_addr == j_addr) bus.imem_rdata = J_WORD;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= 0;
    else if (bus.imem_req && !bus.imem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // a request left unacked must stay asserted with the same address
  logic        prev_req = 1'b0, prev_ack = 1'b0;
  logic [31:0] prev_addr = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req <= 1'b0;
    end else begin
      if (prev_req && !prev_ack) begin
        chk("req_hold", bus.imem_req, 1'b1);
        chk("addr_hold", bus.imem_addr, prev_addr);
      end
      prev_req  <= bus.imem_req;
      prev_ack  <= bus.imem_ack;
      prev_addr <= bus.imem_addr;
    end
  end

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] imm;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_vld;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic s, logic b, logic [31:0] im, logic rq,
                              logic [31:0] ad, logic v, logic [31:0] p, logic [31:0] w);
    vec_t r;
    r.stall = s; r.br = b; r.imm = im; r.exp_req = rq; r.exp_addr = ad;
    r.exp_vld = v; r.exp_pc = p; r.exp_inst = w;
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic        found, addr_seen, ack_prev;
    //              stall br  imm           req addr          vld pc            inst
    vecs[0]  = mk(0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        NOP);
    vecs[1]  = mk(0, 0, 32'h0,        1, 32'h4,        1, 32'h4,        32'hA000_0000);
    vecs[2]  = mk(1, 0, 32'h0,        1, 32'h8,        1, 32'h8,        32'hA000_0004);
    vecs[3]  = mk(1, 0, 32'h0,        1, 32'hC,        1, 32'h8,        32'hA000_0004);
    vecs[4]  = mk(1, 0, 32'h0,        0, 32'h10,       1, 32'h8,        32'hA000_0004);
    vecs[5]  = mk(0, 0, 32'h0,        0, 32'h10,       1, 32'h8,        32'hA000_0004);
    vecs[6]  = mk(0, 0, 32'h0,        1, 32'h10,       1, 32'hC,        32'hA000_0008);
    vecs[7]  = mk(0, 0, 32'h0,        1, 32'h14,       1, 32'h10,       32'hA000_000C);
    vecs[8]  = mk(0, 1, 32'hFFFF_FFFC, 1, 32'h18,      1, 32'h14,       32'hA000_0010);
    vecs[9]  = mk(0, 0, 32'h0,        1, 32'h4,        0, 32'h0,        NOP);
    vecs[10] = mk(1, 1, 32'h40,       1, 32'h8,        1, 32'h8,        32'hA000_0004);
    vecs[11] = mk(0, 0, 32'h0,        1, 32'hC,        1, 32'h8,        32'hA000_0004);
    vecs[12] = mk(0, 1, 32'hFFFF_FFFC, 1, 32'h10,      1, 32'hC,        32'hA000_0008);
    vecs[13] = mk(0, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, 32'h0,       NOP);
    vecs[14] = mk(0, 0, 32'h0,        1, 32'h0,        1, 32'h0,        32'hFFFF_FFFC);
    vecs[15] = mk(0, 0, 32'h0,        1, 32'h4,        1, 32'h4,        32'hA000_0000);

    // reset state
    @(negedge clk);
    chk("rst_req", bus.imem_req, 1'b0);
    chk("rst_vld", inst_valid, 1'b0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, NOP);
    @(negedge clk);
    rst_n = 1'b1;

    // zero-wait table
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d_req", i), bus.imem_req, vecs[i].exp_req);
      chk($sformatf("v%0d_addr", i), bus.imem_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_vld", i), inst_valid, vecs[i].exp_vld);
      chk($sformatf("v%0d_inst", i), inst, vecs[i].exp_inst);
      if (vecs[i].exp_vld) chk($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
      stall = vecs[i].stall;
      br    = vecs[i].br;
      imm   = vecs[i].imm;
    end

    // jump over a slow memory: J fetched from 0x8, stale request to 0xC
    @(negedge clk);
    #2 rst_n = 1'b0;
    lat = 3;
    j_addr = 32'h8;
    @(negedge clk);
    #2 rst_n = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (inst_valid && pc == 32'hC) found = 1'b1;
    end
    chk("j_seen", found, 1'b1);
    chk("j_inst", inst, J_WORD);
    chk("j_req_live", bus.imem_req & ~bus.imem_ack, 1'b1);
    br = 1'b1;
    imm = 32'h40;
    @(negedge clk);
    br = 1'b0;
    imm = '0;
    chk("j_bubble_vld", inst_valid, 1'b0);
    chk("j_bubble_inst", inst, NOP);
    chk("j_stale_req", bus.imem_req, 1'b1);
    chk("j_stale_addr", bus.imem_addr, 32'hC);
    ack_prev = bus.imem_ack;
    addr_seen = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (ack_prev && !addr_seen) begin
        chk("j_new_req", bus.imem_req, 1'b1);
        chk("j_new_addr", bus.imem_addr, 32'h100);
        addr_seen = 1'b1;
      end
      if (inst_valid) begin
        chk("j_first_pc", pc, 32'h104);
        chk("j_first_inst", inst, 32'hA000_0100);
        found = 1'b1;
      end
      if (!addr_seen) ack_prev = bus.imem_ack;
    end
    chk("j_done", found, 1'b1);
    chk("j_addr_seen", addr_seen, 1'b1);

    // reset while the request for 0x104 is waiting
    chk("mid_req_live", bus.imem_req & ~bus.imem_ack, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", bus.imem_req, 1'b0);
    chk("mid_rst_vld", inst_valid, 1'b0);
    chk("mid_rst_inst", inst, NOP);
    chk("mid_rst_pc", pc, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_req", bus.imem_req, 1'b1);
    chk("rel_addr", bus.imem_addr, 32'h0);
    chk("rel_vld", inst_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0000: bubble word driven on inst.
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low; 0 clears all state immediately.
REQ-005 SHALL have port stall, input, 1: decode-stage hold request.
REQ-006 SHALL have port doBranch_id, input, 1: decode resolved a taken branch/jump for the current inst.
REQ-007 SHALL have port imm_for_branch, input, 32: offset (BEQ/BNE) or word target (J/JAL) from decode.
REQ-008 SHALL have port imem_req, output, 1: instruction-memory read request.
REQ-009 SHALL have port imem_addr, output, 32: byte address of request.
REQ-010 SHALL have port imem_ack, input, 1: request completed; imem_rdata valid this cycle.
REQ-011 SHALL have port imem_rdata, input, 32: fetched instruction word.
REQ-012 SHALL have port pc, output, 32: address of inst plus 4 (return address used by JAL).
REQ-013 SHALL have port inst, output, 32: instruction presented to decode.
REQ-014 SHALL have port inst_valid, output, 1: inst is a real fetched instruction, not a bubble.

Function
REQ-015 SHALL hold fetch_pc, a 2-entry {pc+4, word} fetch FIFO, an outstanding flag, and a discard flag.
REQ-016 SHALL assert imem_req when (FIFO entries + outstanding) < 2, with imem_addr = fetch_pc.
REQ-017 SHALL keep imem_req and imem_addr stable from assertion until imem_ack; at most one request outstanding.
REQ-018 On imem_ack with discard clear: SHALL capture {fetch_pc+4, imem_rdata} and advance fetch_pc by 4 (32-bit wrap from 32'hFFFF_FFFC to 0).
REQ-019 On imem_ack with discard set: SHALL drop the data, clear discard, leave fetch_pc unchanged.
REQ-020 When stall=0 and no redirect: SHALL load outputs from FIFO head (pop, inst_valid=1); if FIFO empty and a non-discarded ack occurs this cycle, SHALL bypass it to outputs; otherwise inst=NOP_INST, inst_valid=0, pc unchanged.
REQ-021 Latency: ack in cycle N with empty FIFO and stall=0 SHALL show the word on inst in cycle N+1.
REQ-022 When stall=1: SHALL hold pc, inst, inst_valid; fetching continues until FIFO full.
REQ-023 Redirect SHALL occur when doBranch_id=1, stall=0, inst_valid=1; stall=1 SHALL suppress it.
REQ-024 Redirect target SHALL be imm_for_branch<<2 when inst[31:26] is 6'b000010 or 6'b000011, else pc + (imm_for_branch<<2), truncated to 32 bits.
REQ-025 On redirect, next cycle: fetch_pc=target, FIFO empty, inst=NOP_INST, inst_valid=0; no delay slot.
REQ-026 Redirect with a request outstanding and no ack SHALL set discard; redirect coincident with imem_ack SHALL drop that ack's data, not set discard.
REQ-027 First request to target SHALL be issued the cycle after redirect, or the cycle after the discarded ack.
REQ-028 FIFO full (2 entries) SHALL block requests; push and pop same cycle SHALL keep count.

Reset
REQ-029 On reset=0: fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard=0, imem_req=0, pc=0, inst=NOP_INST, inst_valid=0.
REQ-030 Reset mid-handshake SHALL abandon the request; memory SHALL ignore an ack without a live request.
REQ-031 After reset release, imem_req SHALL assert on the first rising edge with imem_addr=RESET_PC.

Verification
REQ-032 Zero-wait memory (ack same cycle as req), stall=0 -> inst_valid=1 each cycle, pc 4,8,12,...; first word at cycle after first ack.
REQ-033 stall=1 for 3 cycles with FIFO filling -> outputs frozen, imem_req drops after 2 entries, no word lost or duplicated after release.
REQ-034 BEQ at pc=0x14 (inst at 0x10), imm_for_branch=0xFFFF_FFFC, doBranch_id=1 -> next cycle bubble, next imem_addr=0x04.
REQ-035 J with imm_for_branch=0x40, request outstanding with 3-cycle latency -> stale ack dropped, next imem_addr=0x100, first valid pc=0x104.
REQ-036 doBranch_id=1 and stall=1 together -> no redirect, outputs held.
REQ-037 reset=0 asserted mid-request -> outputs cleared asynchronously; after release imem_addr=RESET_PC.
